// File: rtl/ksa_sub_pipe.sv
// ksa_sub_pipe: pipelined unsigned subtractor d = a - b - bin built on a
// Kogge-Stone carry network (a + ~b + ~bin).  Operands are captured on the
// accepting edge, then three stages follow: bitwise G/P, the lower half of
// the prefix levels, and the upper half plus the sum XOR into d.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1.  Input side: in_valid/in_ready, operands are taken on such an edge.
// Output side: out_valid/out_ready, d is retired on such an edge.  The whole
// pipeline moves as one when in_ready = out_ready | ~out_valid, otherwise
// every stage holds; a bubble travels as a stage with its valid bit clear.
module ksa_sub_pipe #(
   parameter int BITS   = 64,
   parameter int LEVELS = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            bin,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [BITS:0]   d,
   output logic            out_valid,
   input  logic            out_ready
);

   // Number of prefix levels resolved in the middle stage
   localparam int HALF = (LEVELS + 1) / 2;

   // Operand capture
   logic            op_v;
   logic [BITS-1:0] op_a;
   logic [BITS-1:0] op_b;
   logic            op_bin;

   // Stage 1: bitwise generate / propagate
   logic            s1_v;
   logic [BITS-1:0] s1_g;
   logic [BITS-1:0] s1_p;
   logic            s1_cin;

   // Stage 2: partial prefix plus the original half-sum for the final XOR
   logic            s2_v;
   logic [BITS-1:0] s2_g;
   logic [BITS-1:0] s2_p;
   logic [BITS-1:0] s2_h;
   logic            s2_cin;

   logic [BITS-1:0] nb;
   logic [BITS-1:0] gen;
   logic [BITS-1:0] prop;
   logic [BITS-1:0] g_in;
   logic            cin;
   logic [BITS-1:0] sum;

   logic [HALF:0][BITS-1:0]        lo_g;
   logic [HALF:0][BITS-1:0]        lo_p;
   logic [LEVELS:HALF][BITS-1:0]   hi_g;
   logic [LEVELS-1:HALF][BITS-1:0] hi_p;

   assign in_ready = out_ready | ~out_valid;

   // Subtraction as addition of the one's complement; the carry-in (~bin) is
   // folded into bit 0's generate so the prefix tree yields true carries.
   assign nb   = ~op_b;
   assign cin  = ~op_bin;
   assign gen  = op_a & nb;
   assign prop = op_a ^ nb;
   assign g_in = {gen[BITS-1:1], gen[0] | (prop[0] & cin)};

   assign lo_g[0] = s1_g;
   assign lo_p[0] = s1_p;
   assign hi_g[HALF] = s2_g;
   assign hi_p[HALF] = s2_p;

   genvar k, i;
   // Lower prefix levels, evaluated between S1 and S2
   for (k = 0; k < HALF; k++) begin : g_lo
      for (i = 0; i < BITS; i++) begin : g_bit
         if (i >= (1 << k)) begin : g_op
            assign lo_g[k+1][i] = lo_g[k][i] | (lo_p[k][i] & lo_g[k][i-(1<<k)]);
            assign lo_p[k+1][i] = lo_p[k][i] & lo_p[k][i-(1<<k)];
         end else begin : g_pass
            assign lo_g[k+1][i] = lo_g[k][i];
            assign lo_p[k+1][i] = lo_p[k][i];
         end
      end
   end

   // Upper prefix levels, evaluated between S2 and S3; last level needs no P
   for (k = HALF; k < LEVELS; k++) begin : g_hi
      for (i = 0; i < BITS; i++) begin : g_bit
         if (i >= (1 << k)) begin : g_op
            assign hi_g[k+1][i] = hi_g[k][i] | (hi_p[k][i] & hi_g[k][i-(1<<k)]);
            if (k < LEVELS - 1) begin : g_pp
               assign hi_p[k+1][i] = hi_p[k][i] & hi_p[k][i-(1<<k)];
            end
         end else begin : g_pass
            assign hi_g[k+1][i] = hi_g[k][i];
            if (k < LEVELS - 1) begin : g_pp
               assign hi_p[k+1][i] = hi_p[k][i];
            end
         end
      end
   end

   // hi_g[LEVELS][i] is the carry out of bit i; bit i's carry-in is bit i-1's
   assign sum = s2_h ^ {hi_g[LEVELS][BITS-2:0], s2_cin};

   // Valid bits and the result register; reset overrides any handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         op_v      <= 1'b0;
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         out_valid <= 1'b0;
         d         <= '0;
      end else if (in_ready) begin
         op_v      <= in_valid;
         s1_v      <= op_v;
         s2_v      <= s1_v;
         out_valid <= s2_v;
         if (s2_v) begin
            d <= {~hi_g[LEVELS][BITS-1], sum};
         end
      end
   end

   // Datapath registers advance with the pipeline; operands only on a transfer
   always_ff @(posedge clk) begin
      if (in_ready) begin
         if (in_valid) begin
            op_a   <= a;
            op_b   <= b;
            op_bin <= bin;
         end
         s1_g   <= g_in;
         s1_p   <= prop;
         s1_cin <= cin;
         s2_g   <= lo_g[HALF];
         s2_p   <= lo_p[HALF];
         s2_h   <= s1_p;
         s2_cin <= s1_cin;
      end
   end

endmodule

// File: doc/ksa_sub_pipe.md
KSA_SUB_PIPE -- requirements
Module: ksa_sub_pipe

Interface
REQ-001 SHALL have parameter BITS, default 64, operand width in bits.
REQ-002 SHALL have parameter LEVELS, default 6, Kogge-Stone prefix levels; LEVELS = log2(BITS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port a  input  BITS  minuend.
REQ-006 SHALL have port b  input  BITS  subtrahend.
REQ-007 SHALL have port bin  input  1  borrow-in.
REQ-008 SHALL have port in_valid  input  1  a/b/bin valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-010 SHALL have port d  output  BITS+1  d[BITS-1:0] is the difference, d[BITS] is borrow-out.
REQ-011 SHALL have port out_valid  output  1  d holds a valid result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts d this cycle.

Function
REQ-013 SHALL compute d[BITS-1:0] = (a - b - bin) mod 2^BITS, and d[BITS] = 1 iff a < b + bin (unsigned).
REQ-014 SHALL implement the subtraction as a + ~b + ~bin through a Kogge-Stone parallel-prefix carry network; borrow-out SHALL be the inverted final carry.
REQ-015 SHALL use three register stages: S1 = registered operands with bitwise G/P; S2 = prefix levels 0..ceil(LEVELS/2)-1; S3 = remaining levels plus the sum XOR, driving d.
REQ-016 SHALL have a latency of exactly 3 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid with the result at edge N+3, provided no stall occurs.
REQ-017 SHALL carry a valid bit with each stage; stage contents without a valid bit SHALL NOT be presented as results.
REQ-018 SHALL drive in_ready = out_ready | ~out_valid (combinational), so the pipeline advances whenever the output is free or being drained.
REQ-019 SHALL advance all stages together when in_ready = 1; when in_ready = 0 every stage register and valid bit SHALL hold.
REQ-020 SHALL load S1 valid with in_valid on each advancing edge, so bubbles propagate as invalid stages.
REQ-021 SHALL keep d and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL sustain one result per cycle with out_ready held at 1 and in_valid held at 1.
REQ-023 SHALL remove a result on the edge where out_valid & out_ready; a new input accepted on the same edge SHALL be legal (simultaneous drain and fill).
REQ-024 SHALL ignore a, b and bin when in_valid = 0 or in_ready = 0.
REQ-025 SHALL handle the wrap-around cases a = 0, b = 2^BITS-1, bin = 1 and a = b, bin = 0 per REQ-013 with no special casing.

Reset
REQ-026 SHALL, on a rising clk edge with rst = 1, clear all stage valid bits, out_valid and d to 0.
REQ-027 SHALL give rst priority over every handshake; results in flight at reset SHALL be discarded and never appear on d.
REQ-028 SHALL drive in_ready = 1 during and immediately after reset (follows REQ-018 with out_valid = 0).

Verification
REQ-029 Reset: hold rst = 1 for 2 cycles with in_valid = 1 -> out_valid = 0 and d = 0 through reset; out_valid stays 0 for 3 cycles after release if in_valid = 0.
REQ-030 Basic, BITS = 64: a = 10, b = 3, bin = 0 accepted at edge N -> at N+3, d[63:0] = 7, d[64] = 0, out_valid = 1.
REQ-031 Wrap, BITS = 64: a = 0, b = 2^64-1, bin = 1 -> d[63:0] = 0, d[64] = 1; then a = b = 0x8000_0000_0000_0000, bin = 0 -> d = 0, borrow 0.
REQ-032 Stall: stream 6 back-to-back inputs, drop out_ready for 4 cycles after the first result -> d held stable, in_ready = 0 during stall, all 6 results delivered in order with none lost or duplicated.
REQ-033 Throughput/bubbles: in_valid pattern 1,0,1,1,0,1 with out_ready = 1 -> out_valid pattern 1,0,1,1,0,1 delayed by exactly 3 cycles, results matching a reference model.
REQ-034 Reset mid-flight: accept 3 inputs, assert rst for 1 cycle before the first result is due -> none of the 3 results ever appears; the next accepted input returns after 3 cycles.
